// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared widths, block sizes and state encodings for the sorting pipeline
package sort_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int BLK_IN     = 8;
    localparam int BLK_OUT    = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT2 = 2'd1;
    localparam logic [1:0] ST_MERGE = 2'd2;

endpackage

// File: rtl/merge_head_sel.sv
// rtl/merge_head_sel.sv - picks which buffer head is emitted next in a descending two-way merge
module merge_head_sel #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] head_a,
    input  logic [DATA_WIDTH-1:0] head_b,
    input  logic [3:0]            rem_a,
    input  logic [3:0]            rem_b,
    output logic                  take_a
);

    // Strictly-greater compare so equal heads go to the second-arrived block (b);
    // an exhausted b forces a, an exhausted a can never win.
    assign take_a = (rem_b == 4'd0) | ((rem_a != 4'd0) & (head_a > head_b));

endmodule

// File: rtl/level_4_merge.sv
// rtl/level_4_merge.sv - serial merge of two sorted 8-element blocks into one 16-element block; option LEVEL4_HOLD_OUTPUT_EN
module level_4_merge
    import sort_pkg::*;
#(
    parameter int DATA_WIDTH = sort_pkg::DATA_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [BLK_IN*DATA_WIDTH-1:0]    idata,
    input  logic                            ivalid,
    output logic [BLK_OUT*DATA_WIDTH-1:0]   odata,
    output logic                            ovalid,
    output logic                            obusy,
    output logic                            odrop
);

    localparam int IW = BLK_IN * DATA_WIDTH;
    localparam int OW = BLK_OUT * DATA_WIDTH;
    localparam logic [3:0] REM_FULL = 4'(BLK_IN);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [IW-1:0]         buf_a;
    logic [IW-1:0]         buf_b;
    logic [3:0]            rem_a;
    logic [3:0]            rem_b;
    logic [3:0]            cnt;
    logic                  take_a;
    logic [DATA_WIDTH-1:0] head_a;
    logic [DATA_WIDTH-1:0] head_b;
    logic [DATA_WIDTH-1:0] head;
    logic [OW-1:0]         shift_base;

    assign head_a = buf_a[IW-1 -: DATA_WIDTH];
    assign head_b = buf_b[IW-1 -: DATA_WIDTH];
    assign head   = take_a ? head_a : head_b;
    assign obusy  = (state == ST_MERGE);

`ifdef LEVEL4_HOLD_OUTPUT_EN
    // odata still holds the previous result on the first merge step, so start from zero.
    assign shift_base = (cnt == 4'd0) ? '0 : odata;
`else
    // odata is already zero on entry to MERGE in this build.
    assign shift_base = odata;
`endif

    merge_head_sel #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_head_sel (
        .head_a (head_a),
        .head_b (head_b),
        .rem_a  (rem_a),
        .rem_b  (rem_b),
        .take_a (take_a)
    );

    // Next-state: capture A, capture B, then 16 merge steps.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (ivalid) state_nxt = ST_WAIT2;
            ST_WAIT2: if (ivalid) state_nxt = ST_MERGE;
            ST_MERGE: if (cnt == 4'd15) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: block capture, one merge step per MERGE cycle, output pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            buf_a  <= '0;
            buf_b  <= '0;
            odata  <= '0;
            cnt    <= 4'd0;
            rem_a  <= 4'd0;
            rem_b  <= 4'd0;
            ovalid <= 1'b0;
            odrop  <= 1'b0;
        end else begin
            state  <= state_nxt;
            ovalid <= 1'b0;
            odrop  <= 1'b0;
            case (state)
                ST_IDLE: begin
`ifndef LEVEL4_HOLD_OUTPUT_EN
                    odata <= '0;
`endif
                    if (ivalid) buf_a <= idata;
                end
                ST_WAIT2: begin
`ifndef LEVEL4_HOLD_OUTPUT_EN
                    odata <= '0;
`endif
                    if (ivalid) begin
                        buf_b <= idata;
                        rem_a <= REM_FULL;
                        rem_b <= REM_FULL;
                        cnt   <= 4'd0;
                    end
                end
                ST_MERGE: begin
                    // Blocks arriving mid-merge are dropped without touching the buffers.
                    odrop <= ivalid;
                    odata <= {shift_base[OW-DATA_WIDTH-1:0], head};
                    if (take_a) begin
                        buf_a <= buf_a << DATA_WIDTH;
                        rem_a <= (rem_a == 4'd0) ? 4'd0 : rem_a - 4'd1;
                    end else begin
                        buf_b <= buf_b << DATA_WIDTH;
                        rem_b <= (rem_b == 4'd0) ? 4'd0 : rem_b - 4'd1;
                    end
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) ovalid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
